alu_seq: RTL and testbench

Parametrised, registered successor to the 6502 combinational ALU. It adds WIDTH generality, valid/ready handshakes on input and output, and rotate operations. It also adds multi-cycle barrel-free shifts by N bits and optional multi-cycle BCD arithmetic. It sits between the instruction sequencer (producer) and the register-file/flag writeback stage (consumer).

---
 rtl/alu_seq.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes,
// multi-cycle N-bit shifts and optional BCD (macro ALU_DECIMAL_EN).
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             carry_in,
  input  logic             decimal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_overflow
);

  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef ALU_DECIMAL_EN
    , S_BCD
`endif
  } state_t;

  state_t             r_state, w_state;
  logic               r_ov, w_ov;
  logic [WIDTH-1:0]   r_out, w_out;
  logic               r_c, w_c, r_z, w_z;
  logic               r_n, w_n, r_v, w_v;
  logic [WIDTH-1:0]   r_a, w_a;
  logic [SHW-1:0]     r_cnt, w_cnt;
  logic               r_left, w_left;
  logic               r_sc, w_sc;

  logic               w_accept;
  logic [WIDTH-1:0]   w_bb;
  logic [WIDTH:0]     w_sum;
  logic [SHW-1:0]     w_amt;
  logic               w_multi;
  logic [WIDTH-1:0]   w_res;
  logic               w_rc, w_rv;
  logic [WIDTH-1:0]   w_sa;
  logic               w_sco;
  logic               w_ld, w_ld_c, w_ld_v;
  logic [WIDTH-1:0]   w_ld_val;

`ifdef ALU_DECIMAL_EN
  localparam int NDIG = WIDTH / 4;

  logic [WIDTH-1:0]   r_b, w_b;
  logic [WIDTH-1:0]   r_acc, w_acc;
  logic               r_sub, w_sub;
  logic               w_dec, w_is_sub;
  logic [4:0]         w_dg0, w_dgk;
  logic [WIDTH-1:0]   w_acc0, w_acck;

  // One BCD digit step: {carry/no-borrow out, digit}
  function automatic logic [4:0] bcd_digit(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       c,
    input logic       sub
  );
    logic [4:0] s;
    logic [5:0] d;
    logic [4:0] r;
    s = {1'b0, a} + {1'b0, b} + {4'b0, c};
    d = {2'b0, a} - {2'b0, b} - {5'b0, ~c};
    if (!sub) begin
      if (s > 5'd9) r = {1'b1, s[3:0] + 4'd6};
      else          r = {1'b0, s[3:0]};
    end else begin
      if (d[5]) r = {1'b0, d[3:0] + 4'd10};
      else      r = {1'b1, d[3:0]};
    end
    return r;
  endfunction

  assign w_is_sub = (operation == 4'd1);
  assign w_dec    = decimal &&
                    (operation == 4'd0 || w_is_sub);
  assign w_dg0 = bcd_digit(input_a[3:0], input_b[3:0],
                           carry_in, w_is_sub);
  assign w_dgk = bcd_digit(r_a[3:0], r_b[3:0], r_sc, r_sub);
  assign w_acc0 = WIDTH'(w_dg0[3:0]) << (WIDTH - 4);
  assign w_acck = (WIDTH'(w_dgk[3:0]) << (WIDTH - 4))
                | (r_acc >> 4);
`else
  logic w_unused;
  assign w_unused = decimal;
`endif

  assign in_ready = (r_state == S_IDLE) && (!r_ov || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_bb  = (operation == 4'd1) ? ~input_b : input_b;
  assign w_sum = {1'b0, input_a} + {1'b0, w_bb}
               + {{WIDTH{1'b0}}, carry_in};
  assign w_amt = input_b[SHW-1:0];
  assign w_multi = (operation == 4'd9 || operation == 4'd10)
                && (w_amt > SHW'(1));

  assign w_sa  = r_left ? {r_a[M-1:0], 1'b0}
                        : {1'b0, r_a[M:1]};
  assign w_sco = r_left ? r_a[M] : r_a[0];

  // Single-step result from the live request inputs
  always_comb begin
    w_res = input_a;
    w_rc  = carry_in;
    w_rv  = 1'b0;
    case (operation)
      4'd0, 4'd1: begin
        w_res = w_sum[M:0];
        w_rc  = w_sum[WIDTH];
        w_rv  = (input_a[M] == w_bb[M]) &&
                (w_sum[M] != input_a[M]);
      end
      4'd2: begin w_res = input_a & input_b; w_rc = 1'b0; end
      4'd3: begin w_res = input_a | input_b; w_rc = 1'b0; end
      4'd4: begin w_res = input_a ^ input_b; w_rc = 1'b0; end
      4'd5, 4'd9: begin
        if (operation == 4'd5 || w_amt != '0) begin
          w_res = {input_a[M-1:0], 1'b0};
          w_rc  = input_a[M];
        end
      end
      4'd6, 4'd10: begin
        if (operation == 4'd6 || w_amt != '0) begin
          w_res = {1'b0, input_a[M:1]};
          w_rc  = input_a[0];
        end
      end
      4'd7: begin
        w_res = {input_a[M-1:0], carry_in};
        w_rc  = input_a[M];
      end
      4'd8: begin
        w_res = {carry_in, input_a[M:1]};
        w_rc  = input_a[0];
      end
      default: ;
    endcase
  end

  // Next-state and output-load decisions
  always_comb begin
    w_state = r_state;
    w_ov    = r_ov;
    w_out   = r_out;
    w_c     = r_c;
    w_z     = r_z;
    w_n     = r_n;
    w_v     = r_v;
    w_a     = r_a;
    w_cnt   = r_cnt;
    w_left  = r_left;
    w_sc    = r_sc;
`ifdef ALU_DECIMAL_EN
    w_b     = r_b;
    w_acc   = r_acc;
    w_sub   = r_sub;
`endif
    w_ld     = 1'b0;
    w_ld_val = r_out;
    w_ld_c   = 1'b0;
    w_ld_v   = 1'b0;
    if (r_ov && out_ready) w_ov = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_multi) begin
            w_state = S_SHIFT;
            w_a     = w_res;
            w_sc    = w_rc;
            w_left  = (operation == 4'd9);
            w_cnt   = w_amt - SHW'(1);
          end
`ifdef ALU_DECIMAL_EN
          else if (w_dec) begin
            if (NDIG == 1) begin
              w_ld     = 1'b1;
              w_ld_val = w_acc0;
              w_ld_c   = w_dg0[4];
            end else begin
              w_state = S_BCD;
              w_a     = input_a >> 4;
              w_b     = input_b >> 4;
              w_acc   = w_acc0;
              w_sc    = w_dg0[4];
              w_sub   = w_is_sub;
              w_cnt   = SHW'(NDIG - 1);
            end
          end
`endif
          else begin
            w_ld     = 1'b1;
            w_ld_val = w_res;
            w_ld_c   = w_rc;
            w_ld_v   = w_rv;
          end
        end
      end
      S_SHIFT: begin
        w_a   = w_sa;
        w_sc  = w_sco;
        w_cnt = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          w_state  = S_IDLE;
          w_ld     = 1'b1;
          w_ld_val = w_sa;
          w_ld_c   = w_sco;
        end
      end
`ifdef ALU_DECIMAL_EN
      S_BCD: begin
        w_a   = r_a >> 4;
        w_b   = r_b >> 4;
        w_acc = w_acck;
        w_sc  = w_dgk[4];
        w_cnt = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          w_state  = S_IDLE;
          w_ld     = 1'b1;
          w_ld_val = w_acck;
          w_ld_c   = w_dgk[4];
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase
    if (w_ld) begin
      w_ov  = 1'b1;
      w_out = w_ld_val;
      w_c   = w_ld_c;
      w_v   = w_ld_v;
      w_z   = (w_ld_val == '0);
      w_n   = w_ld_val[M];
    end
  end

  // State register; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ov    <= 1'b0;
      r_out   <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_sc    <= 1'b0;
`ifdef ALU_DECIMAL_EN
      r_b     <= '0;
      r_acc   <= '0;
      r_sub   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_ov    <= w_ov;
      r_out   <= w_out;
      r_c     <= w_c;
      r_z     <= w_z;
      r_n     <= w_n;
      r_v     <= w_v;
      r_a     <= w_a;
      r_cnt   <= w_cnt;
      r_left  <= w_left;
      r_sc    <= w_sc;
`ifdef ALU_DECIMAL_EN
      r_b     <= w_b;
      r_acc   <= w_acc;
      r_sub   <= w_sub;
`endif
    end
  end

  assign out_valid     = r_ov;
  assign alu_out       = r_out;
  assign flag_carry    = r_c;
  assign flag_zero     = r_z;
  assign flag_neg      = r_n;
  assign flag_overflow = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against
// an arithmetic reference model kept in the bench.
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         carry_in;
  logic         decimal;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         flag_carry;
  logic         flag_zero;
  logic         flag_neg;
  logic         flag_overflow;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .operation     (operation),
    .input_a       (input_a),
    .input_b       (input_b),
    .carry_in      (carry_in),
    .decimal       (decimal),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_out       (alu_out),
    .flag_carry    (flag_carry),
    .flag_zero     (flag_zero),
    .flag_neg      (flag_neg),
    .flag_overflow (flag_overflow)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
    logic [7:0]   lat;
  } exp_t;

  function automatic exp_t model(input int op, input int a,
                                 input int b, input bit cin,
                                 input bit dec);
    exp_t e;
    int mask, half, r, c, v, lat, bb, s, sa, sb, n, cc, da, db, d;
    mask = (1 << W) - 1;
    half = 1 << (W - 1);
    r = a; c = int'(cin); v = 0; lat = 1;
    case (op)
      0, 1: begin
        if (DEC_EN && dec) begin
          r = 0; cc = int'(cin);
          for (int k = 0; k < W / 4; k++) begin
            da = (a >> (4 * k)) & 15;
            db = (b >> (4 * k)) & 15;
            if (op == 0) begin
              d = da + db + cc;
              if (d > 9) begin d += 6; cc = 1; end
              else cc = 0;
            end else begin
              d = da - db - (1 - cc);
              if (d < 0) begin d += 10; cc = 0; end
              else cc = 1;
            end
            r |= (d & 15) << (4 * k);
          end
          c = cc; lat = W / 4;
        end else begin
          bb = (op == 1) ? (mask - b) : b;
          s = a + bb + int'(cin);
          r = s & mask;
          c = (s >> W) & 1;
          sa = (a >= half) ? a - (1 << W) : a;
          sb = (bb >= half) ? bb - (1 << W) : bb;
          s = sa + sb + int'(cin);
          v = (s >= half || s < -half) ? 1 : 0;
        end
      end
      2: begin r = a & b; c = 0; end
      3: begin r = a | b; c = 0; end
      4: begin r = a ^ b; c = 0; end
      5: begin r = (a << 1) & mask; c = (a >> (W - 1)) & 1; end
      6: begin r = a >> 1; c = a & 1; end
      7: begin
        r = ((a << 1) | int'(cin)) & mask;
        c = (a >> (W - 1)) & 1;
      end
      8: begin
        r = (a >> 1) | (int'(cin) << (W - 1));
        c = a & 1;
      end
      9, 10: begin
        n = b % W;
        if (n > 0) begin
          if (op == 9) begin
            r = (a << n) & mask;
            c = (a >> (W - n)) & 1;
          end else begin
            r = a >> n;
            c = (a >> (n - 1)) & 1;
          end
          lat = n;
        end
      end
      default: ;
    endcase
    e.res = r[W-1:0];
    e.c   = c[0];
    e.z   = (r == 0);
    e.n   = r[W-1];
    e.v   = v[0];
    e.lat = lat[7:0];
    return e;
  endfunction

  // Cycle-by-cycle compare against the model
  bit   pend = 1'b0;
  bit   held = 1'b0;
  int   due  = 0;
  int   cyc  = 0;
  exp_t pend_e, held_e;
  logic exp_rdy;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pend = 1'b0;
      held = 1'b0;
    end else begin
      if (pend && cyc == due) begin
        held   = 1'b1;
        held_e = pend_e;
        pend   = 1'b0;
      end
      chk("out_valid", 32'(out_valid), 32'(held));
      exp_rdy = !pend && (!held || out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (held) begin
        chk("alu_out", 32'(alu_out), 32'(held_e.res));
        chk("flags",
            {28'd0, flag_carry, flag_zero, flag_neg, flag_overflow},
            {28'd0, held_e.c, held_e.z, held_e.n, held_e.v});
      end
      if (held && out_ready) held = 1'b0;
      if (in_valid && exp_rdy) begin
        pend_e = model(int'(operation), int'(input_a),
                       int'(input_b), carry_in, decimal);
        pend   = 1'b1;
        due    = cyc + int'(pend_e.lat);
      end
    end
  end

  task automatic run_op(input int op, input int a, input int b,
                        input bit cin, input bit dec,
                        input int res, input logic [3:0] cznv,
                        input int lat, input string nm);
    int k;
    operation = 4'(op);
    input_a   = W'(a);
    input_b   = W'(b);
    carry_in  = cin;
    decimal   = dec;
    in_valid  = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    operation = 4'($urandom);
    input_a   = W'($urandom);
    input_b   = W'($urandom);
    carry_in  = 1'($urandom);
    decimal   = 1'($urandom);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!out_valid)
        chk({nm, " busy"}, 32'(in_ready), 32'd0);
    end while (!out_valid && k < 50);
    chk({nm, " latency"}, 32'(k), 32'(lat));
    chk({nm, " result"}, 32'(alu_out), 32'(res));
    chk({nm, " flags"},
        {28'd0, flag_carry, flag_zero, flag_neg, flag_overflow},
        {28'd0, cznv});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    operation = '0;
    input_a   = '0;
    input_b   = '0;
    carry_in  = 1'b0;
    decimal   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst alu_out", 32'(alu_out), 32'd0);
    chk("rst flags",
        {28'd0, flag_carry, flag_zero, flag_neg, flag_overflow},
        32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    run_op(0, 'h02, 'h02, 0, 0, 'h04, 4'b0000, 1, "add 02+02");
    run_op(0, 'hFF, 'h01, 0, 0, 'h00, 4'b1100, 1, "add ff+01");
    run_op(0, 'h40, 'h40, 0, 0, 'h80, 4'b0011, 1, "add 40+40");
    run_op(1, 'h02, 'h02, 1, 0, 'h00, 4'b1100, 1, "sub c1");
    run_op(1, 'h02, 'h02, 0, 0, 'hFF, 4'b0010, 1, "sub c0");
    run_op(2, 'hFF, 'hFE, 1, 0, 'hFE, 4'b0010, 1, "and");
    run_op(5, 'h0F, 'h00, 0, 0, 'h1E, 4'b0000, 1, "shl");
    run_op(8, 'h01, 'h00, 1, 0, 'h80, 4'b1010, 1, "ror");
    run_op(9, 'h0F, 'h03, 0, 0, 'h78, 4'b0000, 3, "shln 3");
    run_op(9, 'h0F, 'h00, 1, 0, 'h0F, 4'b1000, 1, "shln 0");
    run_op(10, 'hC0, 'h07, 0, 0, 'h01, 4'b1000, 7, "shrn 7");
    run_op(13, 'h00, 'h55, 1, 0, 'h00, 4'b1100, 1, "reserved");
`ifdef ALU_DECIMAL_EN
    run_op(0, 'h19, 'h28, 0, 1, 'h47, 4'b0000, 2, "bcd add");
    run_op(0, 'h99, 'h01, 0, 1, 'h00, 4'b1100, 2, "bcd wrap");
    run_op(1, 'h10, 'h01, 1, 1, 'h09, 4'b1000, 2, "bcd sub");
`else
    run_op(0, 'h19, 'h28, 0, 1, 'h41, 4'b0000, 1, "bin dec");
`endif

    // Backpressure, then transfer and accept on one edge
    out_ready = 1'b0;
    operation = 4'd0;
    input_a   = 'h12;
    input_b   = 'h34;
    carry_in  = 1'b0;
    decimal   = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp hold", 32'(alu_out), 32'h46);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    operation = 4'd4;
    input_a   = 'hF0;
    input_b   = 'h0F;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("bp same-edge ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp next valid", 32'(out_valid), 32'd1);
    chk("bp next result", 32'(alu_out), 32'hFF);
    chk("bp next flags",
        {28'd0, flag_carry, flag_zero, flag_neg, flag_overflow},
        32'b0010);
    @(posedge clk);
    #1;

    // Reset in the middle of a long shift
    operation = 4'd10;
    input_a   = 'h80;
    input_b   = 'h07;
    in_valid  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst alu_out", 32'(alu_out), 32'd0);
    chk("midrst flags",
        {28'd0, flag_carry, flag_zero, flag_neg, flag_overflow},
        32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("midrst stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom % 500) == 0;
      in_valid  = 1'($urandom);
      operation = 4'($urandom);
      input_a   = W'($urandom);
      input_b   = W'($urandom);
      carry_in  = 1'($urandom);
      decimal   = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
